axi_rd_arbiter: RTL

Two-master AXI-lite read-channel arbiter sharing one memory read port between the instruction fetch unit and the load/store unit. It sits between both masters' AR/R channels and the single memory-side AR/R channel. It allows one outstanding transaction at a time and chooses round-robin between the two masters when both request in the same cycle. Write channels do not pass through this block.

---
 rtl/axi_rd_arb_pkg.sv | 20 ++
 rtl/axi_rd_arbiter_rr_pick2.sv | 28 ++
 rtl/axi_rd_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the two-master AXI-lite read arbiter.
package axi_rd_arb_pkg;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_t;

  // Requesting master identity; the value doubles as the grant/request bit index
  typedef enum logic {
    IFU = 1'b0,
    LSU = 1'b1
  } master_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_rd_arbiter_rr_pick2.sv
// Two-requester round-robin picker: a lone requester always wins, a tie goes
// to the requester that was not served most recently.
module rr_pick2
  import axi_rd_arb_pkg::*;
(
  input  logic [1:0] req,
  input  master_t    last,
  output logic [1:0] gnt
);

  // Select at most one requester; bit 0 is the IFU, bit 1 the LSU
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (last == IFU) begin
          gnt = 2'b10;
        end else begin
          gnt = 2'b01;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Read-channel arbiter sharing one memory AR/R port between the instruction
// fetch unit and the load/store unit, one outstanding transaction at a time.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_araddr,
  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic [1:0]        ifu_rresp,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic [1:0]        lsu_rresp,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rvalid,
  output logic              mem_rready
);

  state_t     state_r;
  master_t    owner_r;
  master_t    last_r;
  logic [1:0] req_s;
  logic [1:0] gnt_s;

  assign req_s = {lsu_arvalid, ifu_arvalid};

  rr_pick2 u_pick (
    .req  (req_s),
    .last (last_r),
    .gnt  (gnt_s)
  );

  // Address acceptance: only the picked master sees arready, and only in IDLE
  always_comb begin
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    if (state_r == IDLE) begin
      ifu_arready = gnt_s[0];
      lsu_arready = gnt_s[1];
    end else begin
      ifu_arready = 1'b0;
      lsu_arready = 1'b0;
    end
  end

  // Response steering: memory R channel connects to the owner only during DATA
  always_comb begin
    mem_rready = 1'b0;
    ifu_rvalid = 1'b0;
    ifu_rdata  = {DATA_W{1'b0}};
    ifu_rresp  = 2'b00;
    lsu_rvalid = 1'b0;
    lsu_rdata  = {DATA_W{1'b0}};
    lsu_rresp  = 2'b00;
    if (state_r == DATA) begin
      if (owner_r == IFU) begin
        mem_rready = ifu_rready;
        ifu_rvalid = mem_rvalid;
        ifu_rdata  = mem_rdata;
        ifu_rresp  = mem_rresp;
      end else begin
        mem_rready = lsu_rready;
        lsu_rvalid = mem_rvalid;
        lsu_rdata  = mem_rdata;
        lsu_rresp  = mem_rresp;
      end
    end else begin
      mem_rready = 1'b0;
    end
  end

  // Transaction FSM with owner, round-robin history and memory address request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      owner_r     <= IFU;
      last_r      <= IFU;
      mem_arvalid <= 1'b0;
      mem_araddr  <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_s[1]) begin
            mem_araddr  <= lsu_araddr;
            owner_r     <= LSU;
            last_r      <= LSU;
            mem_arvalid <= 1'b1;
            state_r     <= ADDR;
          end else if (gnt_s[0]) begin
            mem_araddr  <= ifu_araddr;
            owner_r     <= IFU;
            last_r      <= IFU;
            mem_arvalid <= 1'b1;
            state_r     <= ADDR;
          end
        end
        ADDR: begin
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            state_r     <= DATA;
          end
        end
        DATA: begin
          if (mem_rvalid && mem_rready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          mem_arvalid <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule
